sd_data_rx_multi: RTL and testbench
===================================

Name: sd_data_rx_multi

Overview:
- Parametrised SD data-line receiver: samples 1-bit or 4-bit DAT bus, reassembles bytes into 32-bit words and streams them with byte addresses.
- Computes per-lane CRC16 internally, no external CRC engine, and checks it against the received CRC and end bit.
- Handles multi-block reads, with a start-bit timeout per block.
- Sits between the SD pad/clock-enable logic and the read buffer; driven by the command sequencer through a level-enable/complete handshake.

Parameters:
- BUS_WIDTH, 4, active DAT lanes; legal values 1 or 4. Lanes above BUS_WIDTH-1 ignored.
- BLOCK_BYTES, 512, bytes per block; multiple of 4, at least 4.
- TIMEOUT_CYCLES, 1048575, max cycles waiting for a start bit per block.

Ports:
- clk  in  1  clock; all sampling on rising edge, one DAT bit per lane per cycle.
- rst  in  1  synchronous, active-high reset.
- Rx_En  in  1  level enable from sequencer; must stay high until Rx_Done is seen.
- Block_Count  in  16  number of blocks to receive; sampled on IDLE exit; 0 treated as 1.
- DATA  in  4  SD DAT[3:0] lines.
- Out_Data  out  32  received word; first-received byte in [7:0], fourth in [31:24].
- Out_Valid  out  1  one-cycle pulse, Out_Data/Out_Addr valid.
- Out_Addr  out  32  byte address of Out_Data[7:0] = block_index*BLOCK_BYTES + offset.
- Block_Done  out  1  one-cycle pulse after each block's end bit.
- Busy  out  1  high in any state except IDLE and DONE.
- Rx_Done  out  1  transfer finished; held while Rx_En high.
- Rx_Crc_Fail  out  1  sticky CRC or end-bit error for this transfer.
- Rx_Timeout  out  1  start bit not seen within TIMEOUT_CYCLES.
- Fail_Block  out  16  index of first failing block; valid when Rx_Crc_Fail.

Behaviour:
- Reset: every output 0, state IDLE, all counters and CRC registers 0.
- Lane bit order: MSB first. In 4-bit mode each cycle delivers one nibble, DATA[3] = byte bit 7/3. In 1-bit mode DATA[0] carries one bit per cycle.
- CRC16 per lane: polynomial x^16+x^12+x^5+1, init 0x0000. Covers only data bits of that lane.
- IDLE:
  - Rx_En high: latch Block_Count, clear status, block_index=0, go WAIT_START.
- WAIT_START:
  - Start bit = all active lanes low.
  - On start bit: clear CRC and bit counters, go DATA.
  - Otherwise increment the wait counter.
  - At TIMEOUT_CYCLES: Rx_Timeout=1, go DONE.
- DATA:
  - Lasts BLOCK_BYTES*8/BUS_WIDTH cycles.
  - A word completes every 32/BUS_WIDTH cycles. Out_Valid pulses the cycle after the last bit of the word.
  - Out_Addr starts at block_index*BLOCK_BYTES and increments by 4.
  - Then go CRC.
- CRC: 16 cycles; capture 16 bits per active lane MSB-first, then go END_BIT.
- END_BIT:
  - Sample one cycle; all active lanes must be 1.
  - Go CHECK.
- CHECK:
  - Compare computed vs received CRC on each active lane, and the end bit.
  - On mismatch: set Rx_Crc_Fail; load Fail_Block if it is the first failure.
  - Pulse Block_Done.
  - If block_index+1 < count: increment block_index, reset timeout counter, go WAIT_START. Else go DONE.
- DONE:
  - Rx_Done=1 while Rx_En high.
  - Rx_En low: clear Rx_Done, Rx_Crc_Fail, Rx_Timeout and Fail_Block; go IDLE the next cycle.
- Rx_En dropped in any other non-IDLE state: abort, go IDLE next cycle. No Rx_Done, no further Out_Valid.
- rst mid-transfer: immediate return to reset values; no partial-word Out_Valid.
- Block_Count changes after IDLE exit: ignored.
- Out_Addr wraps modulo 2^32.

Optional Feature:
- SD_RX_ABORT_ON_CRC_ERR_EN defined:
  - The first CHECK failure goes directly to DONE; remaining blocks are not received.
  - Block_Done still pulses for the failing block.
- Undefined:
  - All Block_Count blocks are received regardless of failures.
  - Rx_Crc_Fail stays sticky; Fail_Block holds the first failing block.

Test Plan:
- BUS_WIDTH=1, one block of 512×0xFF, CRC 0x7FA1, end bit 1:
  - Required: 128 Out_Valid pulses, last Out_Addr=508, Out_Data=0xFFFFFFFF, Rx_Done=1, Rx_Crc_Fail=0.
- BUS_WIDTH=4, one block of bytes 0x00..0xFF repeated, lane CRCs from reference model:
  - Required: first word 0x03020100 at addr 0, one word every 8 cycles, Rx_Crc_Fail=0.
- BUS_WIDTH=4, Block_Count=3, block 1 lane 2 CRC bit flipped:
  - Without macro: 3 Block_Done pulses, final Out_Addr=1532, Rx_Crc_Fail=1, Fail_Block=1.
  - With macro: 2 Block_Done pulses, then DONE.
- TIMEOUT_CYCLES=100, DATA held 0xF:
  - Required: Rx_Timeout=1 and Rx_Done=1 after 100 cycles in WAIT_START; no Out_Valid.
- Rx_En dropped at data cycle 40 of block 0:
  - Required: Busy=0 next cycle, no further Out_Valid, Rx_Done stays 0.
- Bad end bit (lane 0 low) with correct CRC:
  - Required: Rx_Crc_Fail=1, Fail_Block=0.
  - Then Rx_En low: all status outputs 0 within 1 cycle.

Source files
------------

// File: rtl/sd_data_rx_multi_if.sv
// sd_data_rx_multi_if: sequencer/pad-side signal bundle for the SD data receiver.
// The master side is the command sequencer, which also supplies the DAT lines.
// The slave side is the receiver.
interface sd_data_rx_multi_if;
    logic        Rx_En;
    logic [15:0] Block_Count;
    logic [3:0]  DATA;
    logic [31:0] Out_Data;
    logic        Out_Valid;
    logic [31:0] Out_Addr;
    logic        Block_Done;
    logic        Busy;
    logic        Rx_Done;
    logic        Rx_Crc_Fail;
    logic        Rx_Timeout;
    logic [15:0] Fail_Block;

    modport master (
        output Rx_En, Block_Count, DATA,
        input  Out_Data, Out_Valid, Out_Addr, Block_Done, Busy,
               Rx_Done, Rx_Crc_Fail, Rx_Timeout, Fail_Block
    );

    modport slave (
        input  Rx_En, Block_Count, DATA,
        output Out_Data, Out_Valid, Out_Addr, Block_Done, Busy,
               Rx_Done, Rx_Crc_Fail, Rx_Timeout, Fail_Block
    );
endinterface

// File: rtl/sd_data_rx_multi.sv
// sd_data_rx_multi: SD DAT-line receiver for 1-bit or 4-bit buses.
// It reassembles bytes into 32-bit words with byte addresses and checks each
// lane's CRC16 and end bit over multi-block reads.
// There is a start-bit timeout for every block.
// Optional build macro: SD_RX_ABORT_ON_CRC_ERR_EN. When it is defined, the
// transfer ends at the first block that fails its CRC or end-bit check.
module sd_data_rx_multi #(
    parameter int BUS_WIDTH      = 4,
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input logic               clk,
    input logic               rst,
    sd_data_rx_multi_if.slave bus
);
    localparam int unsigned   NL         = (BUS_WIDTH == 1) ? 1 : 4;
    localparam int            PW         = 8 - NL;
    localparam logic [3:0]    LANE_MASK  = (NL == 1) ? 4'b0001 : 4'b1111;
    localparam logic [31:0]   BEATS_LAST = 32'(BLOCK_BYTES * 8 / NL - 1);
    localparam logic [31:0]   BYTE_LAST  = 32'(8 / NL - 1);
    localparam logic [31:0]   WORD_LAST  = 32'(32 / NL - 1);
    localparam int            WW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END_BIT, S_CHECK, S_DONE
    } state_t;

    state_t                 state;
    logic [WW-1:0]          wait_cnt;
    logic [31:0]            bit_cnt;
    logic [PW-1:0]          part;
    logic [7:0]             next_byte;
    logic [23:0]            word_sr;
    logic [31:0]            next_addr;
    logic [15:0]            blk_idx;
    logic [15:0]            blk_total;
    logic [NL-1:0][15:0]    crc_calc;
    logic [NL-1:0][15:0]    crc_rx;
    logic                   end_ok;
    logic [3:0]             lanes;
    logic                   blk_bad;
    logic                   last_blk;
    logic                   stop_xfer;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // Byte being assembled: held partial bits plus this cycle's lane bits, MSB first.
    if (NL == 1) begin : g_w1
        always_comb next_byte = {part, lanes[0]};
    end else begin : g_w4
        always_comb next_byte = {part, lanes};
    end

    // Lane masking and the block verdict and continuation decision used in CHECK.
    always_comb begin
        lanes     = bus.DATA & LANE_MASK;
        blk_bad   = (crc_calc != crc_rx) || !end_ok;
        last_blk  = ({1'b0, blk_idx} + 17'd1) >= {1'b0, blk_total};
`ifdef SD_RX_ABORT_ON_CRC_ERR_EN
        stop_xfer = last_blk || blk_bad;
`else
        stop_xfer = last_blk;
`endif
    end

    // Receive FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            bit_cnt         <= '0;
            part            <= '0;
            word_sr         <= '0;
            next_addr       <= '0;
            blk_idx         <= '0;
            blk_total       <= '0;
            crc_calc        <= '0;
            crc_rx          <= '0;
            end_ok          <= 1'b0;
            bus.Out_Data    <= '0;
            bus.Out_Valid   <= 1'b0;
            bus.Out_Addr    <= '0;
            bus.Block_Done  <= 1'b0;
            bus.Busy        <= 1'b0;
            bus.Rx_Done     <= 1'b0;
            bus.Rx_Crc_Fail <= 1'b0;
            bus.Rx_Timeout  <= 1'b0;
            bus.Fail_Block  <= '0;
        end else begin
            bus.Out_Valid  <= 1'b0;
            bus.Block_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Rx_En) begin
                        blk_total       <= (bus.Block_Count == 16'd0) ? 16'd1 : bus.Block_Count;
                        blk_idx         <= '0;
                        next_addr       <= '0;
                        wait_cnt        <= '0;
                        bus.Rx_Done     <= 1'b0;
                        bus.Rx_Crc_Fail <= 1'b0;
                        bus.Rx_Timeout  <= 1'b0;
                        bus.Fail_Block  <= '0;
                        bus.Busy        <= 1'b1;
                        state           <= S_WAIT_START;
                    end
                end
                S_DONE: begin
                    if (!bus.Rx_En) begin
                        bus.Rx_Done     <= 1'b0;
                        bus.Rx_Crc_Fail <= 1'b0;
                        bus.Rx_Timeout  <= 1'b0;
                        bus.Fail_Block  <= '0;
                        state           <= S_IDLE;
                    end
                end
                default: begin
                    if (!bus.Rx_En) begin
                        // The sequencer dropped the enable mid-transfer. Abandon
                        // the transfer and its status silently.
                        bus.Busy        <= 1'b0;
                        bus.Rx_Crc_Fail <= 1'b0;
                        bus.Rx_Timeout  <= 1'b0;
                        bus.Fail_Block  <= '0;
                        state           <= S_IDLE;
                    end else begin
                        case (state)
                            S_WAIT_START: begin
                                if (lanes == 4'd0) begin
                                    bit_cnt  <= '0;
                                    crc_calc <= '0;
                                    state    <= S_DATA;
                                end else if (wait_cnt == WAIT_LAST) begin
                                    bus.Rx_Timeout <= 1'b1;
                                    bus.Rx_Done    <= 1'b1;
                                    bus.Busy       <= 1'b0;
                                    state          <= S_DONE;
                                end else begin
                                    wait_cnt <= wait_cnt + 1'b1;
                                end
                            end
                            S_DATA: begin
                                for (int unsigned l = 0; l < NL; l++)
                                    crc_calc[l] <= crc16_step(crc_calc[l], lanes[l]);
                                part <= next_byte[PW-1:0];
                                if ((bit_cnt & BYTE_LAST) == BYTE_LAST)
                                    word_sr <= {next_byte, word_sr[23:8]};
                                if ((bit_cnt & WORD_LAST) == WORD_LAST) begin
                                    bus.Out_Valid <= 1'b1;
                                    bus.Out_Data  <= {next_byte, word_sr};
                                    bus.Out_Addr  <= next_addr;
                                    next_addr     <= next_addr + 32'd4;
                                end
                                if (bit_cnt == BEATS_LAST) begin
                                    bit_cnt <= '0;
                                    state   <= S_CRC;
                                end else begin
                                    bit_cnt <= bit_cnt + 32'd1;
                                end
                            end
                            S_CRC: begin
                                for (int unsigned l = 0; l < NL; l++)
                                    crc_rx[l] <= {crc_rx[l][14:0], lanes[l]};
                                if (bit_cnt == 32'd15) state <= S_END_BIT;
                                else bit_cnt <= bit_cnt + 32'd1;
                            end
                            S_END_BIT: begin
                                end_ok <= (lanes == LANE_MASK);
                                state  <= S_CHECK;
                            end
                            S_CHECK: begin
                                bus.Block_Done <= 1'b1;
                                if (blk_bad) begin
                                    bus.Rx_Crc_Fail <= 1'b1;
                                    if (!bus.Rx_Crc_Fail) bus.Fail_Block <= blk_idx;
                                end
                                if (stop_xfer) begin
                                    bus.Rx_Done <= 1'b1;
                                    bus.Busy    <= 1'b0;
                                    state       <= S_DONE;
                                end else begin
                                    blk_idx  <= blk_idx + 16'd1;
                                    wait_cnt <= '0;
                                    state    <= S_WAIT_START;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_data_rx_multi.sv
// tb_sd_data_rx_multi: randomized self-checking bench for sd_data_rx_multi.
// It uses a 1-bit instance, a 4-bit 512-byte instance, and a 4-bit 16-byte
// instance with a 100-cycle timeout.
// Expected words come from the sent byte stream. Expected CRCs come from
// polynomial long division of each lane's bit stream.
module tb_sd_data_rx_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  data_drv;
    logic [15:0] bc;
    logic        en1, en4, ent;
    int          sel;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          bd_cnt = 0;
    logic [63:0] got_q[$];
    int          got_t[$];
    logic [7:0]  blk[$];

    logic        mon_valid, mon_bd, mon_done, mon_fail, mon_to, mon_busy;
    logic [31:0] mon_data, mon_addr;
    logic [15:0] mon_fb;

    always #5 clk = ~clk;

    sd_data_rx_multi_if if1();
    sd_data_rx_multi_if if4();
    sd_data_rx_multi_if ift();

    assign if1.DATA = data_drv;
    assign if4.DATA = data_drv;
    assign ift.DATA = data_drv;
    assign if1.Block_Count = bc;
    assign if4.Block_Count = bc;
    assign ift.Block_Count = bc;
    assign if1.Rx_En = en1;
    assign if4.Rx_En = en4;
    assign ift.Rx_En = ent;

    sd_data_rx_multi #(.BUS_WIDTH(1), .BLOCK_BYTES(512)) u1 (.clk(clk), .rst(rst), .bus(if1));
    sd_data_rx_multi #(.BUS_WIDTH(4), .BLOCK_BYTES(512)) u4 (.clk(clk), .rst(rst), .bus(if4));
    sd_data_rx_multi #(.BUS_WIDTH(4), .BLOCK_BYTES(16), .TIMEOUT_CYCLES(100)) ut (.clk(clk), .rst(rst), .bus(ift));

    // Observe the DUT selected by the running test.
    always_comb begin
        mon_valid = 1'b0; mon_bd = 1'b0; mon_done = 1'b0; mon_fail = 1'b0;
        mon_to = 1'b0; mon_busy = 1'b0; mon_data = '0; mon_addr = '0; mon_fb = '0;
        case (sel)
            0: begin
                mon_valid = if1.Out_Valid; mon_bd = if1.Block_Done; mon_done = if1.Rx_Done;
                mon_fail = if1.Rx_Crc_Fail; mon_to = if1.Rx_Timeout; mon_busy = if1.Busy;
                mon_data = if1.Out_Data; mon_addr = if1.Out_Addr; mon_fb = if1.Fail_Block;
            end
            1: begin
                mon_valid = if4.Out_Valid; mon_bd = if4.Block_Done; mon_done = if4.Rx_Done;
                mon_fail = if4.Rx_Crc_Fail; mon_to = if4.Rx_Timeout; mon_busy = if4.Busy;
                mon_data = if4.Out_Data; mon_addr = if4.Out_Addr; mon_fb = if4.Fail_Block;
            end
            default: begin
                mon_valid = ift.Out_Valid; mon_bd = ift.Block_Done; mon_done = ift.Rx_Done;
                mon_fail = ift.Rx_Crc_Fail; mon_to = ift.Rx_Timeout; mon_busy = ift.Busy;
                mon_data = ift.Out_Data; mon_addr = ift.Out_Addr; mon_fb = ift.Fail_Block;
            end
        endcase
    end

    // Cycle counter for pulse spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every word pulse and block-done pulse of the selected DUT.
    always @(negedge clk) begin
        if (mon_valid) begin
            got_q.push_back({mon_addr, mon_data});
            got_t.push_back(cyc);
        end
        if (mon_bd) bd_cnt = bd_cnt + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference CRC: remainder of lane_bits(x) * x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] model_crc(input int bw, input int lane);
        bit          m[$];
        logic [7:0]  b;
        logic [16:0] gpoly;
        logic [15:0] r;
        gpoly = 17'h11021;
        for (int i = 0; i < blk.size(); i++) begin
            b = blk[i];
            for (int k = 7; k >= 0; k--)
                if ((bw == 1 && lane == 0) || (bw == 4 && (k % 4) == lane)) m.push_back(b[k]);
        end
        repeat (16) m.push_back(1'b0);
        for (int i = 0; i + 16 < m.size(); i++)
            if (m[i]) for (int j = 0; j <= 16; j++) m[i + j] = m[i + j] ^ gpoly[16 - j];
        for (int j = 0; j < 16; j++) r[15 - j] = m[m.size() - 16 + j];
        return r;
    endfunction

    function automatic logic [63:0] model_crcs(input int bw);
        logic [63:0] c;
        c = '0;
        for (int l = 0; l < bw; l++) c[16*l +: 16] = model_crc(bw, l);
        return c;
    endfunction

    task automatic set_en(input logic v);
        case (sel)
            0: en1 = v;
            1: en4 = v;
            default: ent = v;
        endcase
    endtask

    task automatic fill_random(input int n);
        blk.delete();
        for (int i = 0; i < n; i++) blk.push_back(8'($urandom));
    endtask

    // Send idle gap, start bit, blk[] data, CRC, and end bit. Stop after 'limit' data beats if limit >= 0.
    task automatic drive_block(input int bw, input logic [63:0] crcs, input logic [3:0] endv, input int limit);
        int         beats;
        logic [7:0] b;
        beats = 0;
        repeat ($urandom_range(2, 5)) begin
            @(negedge clk); data_drv = (bw == 1) ? {3'($urandom), 1'b1} : 4'hF;
        end
        @(negedge clk); data_drv = (bw == 1) ? {3'($urandom), 1'b0} : 4'h0;
        for (int i = 0; i < blk.size(); i++) begin
            b = blk[i];
            if (bw == 1) begin
                for (int k = 7; k >= 0; k--) begin
                    if (beats == limit) return;
                    @(negedge clk); data_drv = {3'($urandom), b[k]}; beats++;
                end
            end else begin
                if (beats == limit) return;
                @(negedge clk); data_drv = b[7:4]; beats++;
                if (beats == limit) return;
                @(negedge clk); data_drv = b[3:0]; beats++;
            end
        end
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            if (bw == 1) data_drv = {3'($urandom), crcs[i]};
            else data_drv = {crcs[48 + i], crcs[32 + i], crcs[16 + i], crcs[i]};
        end
        @(negedge clk); data_drv = (bw == 1) ? {3'($urandom), endv[0]} : endv;
        @(negedge clk); data_drv = 4'hF;
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 0;
        while (mon_done !== 1'b1 && n < maxc) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
    endtask

    task automatic release_en();
        @(negedge clk); set_en(1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en1 = 1'b0; en4 = 1'b0; ent = 1'b0; data_drv = 4'hF; bc = 16'd1; sel = 1;
        repeat (3) @(negedge clk);
        checks++; if ({if1.Out_Data, if1.Out_Valid, if1.Out_Addr, if1.Block_Done, if1.Busy, if1.Rx_Done,
                       if1.Rx_Crc_Fail, if1.Rx_Timeout, if1.Fail_Block} !== 86'd0) begin
            errors++; $display("FAIL reset_u1: outputs not all zero (data=%h addr=%h)", if1.Out_Data, if1.Out_Addr); end
        checks++; if ({if4.Out_Data, if4.Out_Valid, if4.Out_Addr, if4.Block_Done, if4.Busy, if4.Rx_Done,
                       if4.Rx_Crc_Fail, if4.Rx_Timeout, if4.Fail_Block} !== 86'd0) begin
            errors++; $display("FAIL reset_u4: outputs not all zero (data=%h addr=%h)", if4.Out_Data, if4.Out_Addr); end
        checks++; if ({ift.Out_Data, ift.Out_Valid, ift.Out_Addr, ift.Block_Done, ift.Busy, ift.Rx_Done,
                       ift.Rx_Crc_Fail, ift.Rx_Timeout, ift.Fail_Block} !== 86'd0) begin
            errors++; $display("FAIL reset_ut: outputs not all zero (data=%h addr=%h)", ift.Out_Data, ift.Out_Addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_w1_ones();
        int g, b0, n;
        logic [63:0] e;
        sel = 0; bc = 16'd1; g = got_q.size(); b0 = bd_cnt;
        blk.delete();
        for (int i = 0; i < 512; i++) blk.push_back(8'hFF);
        @(negedge clk); set_en(1'b1);
        drive_block(1, 64'h7FA1, 4'h1, -1);
        wait_done(100, n);
        checks++; if (got_q.size() - g !== 128) begin
            errors++; $display("FAIL w1_count: got %0d words, expected 128", got_q.size() - g); end
        for (int w = 0; w < 128 && g + w < got_q.size(); w++) begin
            e = {32'(4 * w), blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
            checks++; if (got_q[g + w] !== e) begin
                errors++; $display("FAIL w1_word%0d: got %h expected %h", w, got_q[g + w], e); end
        end
        checks++; if (got_q[got_q.size() - 1] !== {32'd508, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL w1_last: got %h expected %h", got_q[got_q.size() - 1], {32'd508, 32'hFFFF_FFFF}); end
        checks++; if (mon_done !== 1'b1) begin errors++; $display("FAIL w1_done: got %b expected 1", mon_done); end
        checks++; if (mon_fail !== 1'b0) begin errors++; $display("FAIL w1_crc: got %b expected 0", mon_fail); end
        checks++; if (mon_busy !== 1'b0) begin errors++; $display("FAIL w1_busy: got %b expected 0", mon_busy); end
        checks++; if (bd_cnt - b0 !== 1) begin errors++; $display("FAIL w1_blkdone: got %0d expected 1", bd_cnt - b0); end
        release_en();
        checks++; if (mon_done !== 1'b0) begin errors++; $display("FAIL w1_done_clr: got %b expected 0", mon_done); end
    endtask

    task automatic test_w4_ramp();
        int g, n;
        logic [63:0] e;
        sel = 1; bc = 16'd1; g = got_q.size();
        blk.delete();
        for (int i = 0; i < 512; i++) blk.push_back(8'(i));
        @(negedge clk); set_en(1'b1);
        drive_block(4, model_crcs(4), 4'hF, -1);
        wait_done(100, n);
        checks++; if (got_q.size() - g !== 128) begin
            errors++; $display("FAIL w4_count: got %0d words, expected 128", got_q.size() - g); end
        checks++; if (got_q[g] !== {32'd0, 32'h0302_0100}) begin
            errors++; $display("FAIL w4_first: got %h expected %h", got_q[g], {32'd0, 32'h0302_0100}); end
        for (int w = 0; w < 128 && g + w < got_q.size(); w++) begin
            e = {32'(4 * w), blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
            checks++; if (got_q[g + w] !== e) begin
                errors++; $display("FAIL w4_word%0d: got %h expected %h", w, got_q[g + w], e); end
            if (w > 0) begin
                checks++; if (got_t[g + w] - got_t[g + w - 1] !== 8) begin
                    errors++; $display("FAIL w4_spacing%0d: got %0d cycles expected 8", w, got_t[g + w] - got_t[g + w - 1]); end
            end
        end
        checks++; if (mon_done !== 1'b1) begin errors++; $display("FAIL w4_done: got %b expected 1", mon_done); end
        checks++; if (mon_fail !== 1'b0) begin errors++; $display("FAIL w4_crc: got %b expected 0", mon_fail); end
        release_en();
    endtask

    task automatic test_multi_block();
        int g, b0, n, nb;
        logic [63:0] c, e;
`ifdef SD_RX_ABORT_ON_CRC_ERR_EN
        nb = 2;
`else
        nb = 3;
`endif
        sel = 1; bc = 16'd3; g = got_q.size(); b0 = bd_cnt;
        @(negedge clk); set_en(1'b1);
        for (int bi = 0; bi < nb; bi++) begin
            fill_random(512);
            c = model_crcs(4);
            if (bi == 1) c[32 + 5] = ~c[32 + 5];
            drive_block(4, c, 4'hF, -1);
            if (bi == 0) bc = 16'd1;
            for (int w = 0; w < 128 && g + 128*bi + w < got_q.size(); w++) begin
                e = {32'(512 * bi + 4 * w), blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
                checks++; if (got_q[g + 128*bi + w] !== e) begin
                    errors++; $display("FAIL multi_b%0d_word%0d: got %h expected %h", bi, w, got_q[g + 128*bi + w], e); end
            end
        end
        wait_done(100, n);
        checks++; if (mon_done !== 1'b1) begin errors++; $display("FAIL multi_done: got %b expected 1", mon_done); end
        checks++; if (bd_cnt - b0 !== nb) begin errors++; $display("FAIL multi_blkdone: got %0d expected %0d", bd_cnt - b0, nb); end
        checks++; if (got_q.size() - g !== 128 * nb) begin
            errors++; $display("FAIL multi_count: got %0d expected %0d", got_q.size() - g, 128 * nb); end
        checks++; if (got_q[got_q.size() - 1][63:32] !== 32'(512 * nb - 4)) begin
            errors++; $display("FAIL multi_lastaddr: got %0d expected %0d", got_q[got_q.size() - 1][63:32], 512 * nb - 4); end
        checks++; if (mon_fail !== 1'b1) begin errors++; $display("FAIL multi_crcfail: got %b expected 1", mon_fail); end
        checks++; if (mon_fb !== 16'd1) begin errors++; $display("FAIL multi_failblk: got %0d expected 1", mon_fb); end
        repeat (40) @(negedge clk);
        checks++; if (bd_cnt - b0 !== nb) begin errors++; $display("FAIL multi_noextra: got %0d expected %0d", bd_cnt - b0, nb); end
        release_en();
        checks++; if ({mon_done, mon_fail, mon_fb} !== 18'd0) begin
            errors++; $display("FAIL multi_clr: got done=%b fail=%b fb=%0d expected 0", mon_done, mon_fail, mon_fb); end
    endtask

    task automatic test_count_zero();
        int g, b0, n;
        logic [63:0] e;
        sel = 2; bc = 16'd0; g = got_q.size(); b0 = bd_cnt;
        fill_random(16);
        @(negedge clk); set_en(1'b1);
        drive_block(4, model_crcs(4), 4'hF, -1);
        wait_done(60, n);
        checks++; if (mon_done !== 1'b1) begin errors++; $display("FAIL cz_done: got %b expected 1", mon_done); end
        checks++; if (bd_cnt - b0 !== 1) begin errors++; $display("FAIL cz_blkdone: got %0d expected 1", bd_cnt - b0); end
        checks++; if (mon_fail !== 1'b0) begin errors++; $display("FAIL cz_crc: got %b expected 0", mon_fail); end
        checks++; if (got_q.size() - g !== 4) begin errors++; $display("FAIL cz_count: got %0d expected 4", got_q.size() - g); end
        for (int w = 0; w < 4 && g + w < got_q.size(); w++) begin
            e = {32'(4 * w), blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
            checks++; if (got_q[g + w] !== e) begin
                errors++; $display("FAIL cz_word%0d: got %h expected %h", w, got_q[g + w], e); end
        end
        release_en();
    endtask

    task automatic test_timeout();
        int g, n;
        sel = 2; bc = 16'd1; g = got_q.size(); data_drv = 4'hF;
        @(negedge clk); set_en(1'b1);
        n = 0;
        while (mon_done !== 1'b1 && n < 300) begin
            @(negedge clk); n++;
        end
        checks++; if (n !== 101) begin errors++; $display("FAIL to_latency: got %0d cycles expected 101", n); end
        checks++; if (mon_to !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", mon_to); end
        checks++; if (mon_done !== 1'b1) begin errors++; $display("FAIL to_done: got %b expected 1", mon_done); end
        checks++; if (mon_busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", mon_busy); end
        checks++; if (got_q.size() - g !== 0) begin errors++; $display("FAIL to_novalid: got %0d expected 0", got_q.size() - g); end
        release_en();
        checks++; if (mon_to !== 1'b0) begin errors++; $display("FAIL to_clr: got %b expected 0", mon_to); end
    endtask

    task automatic test_abort();
        int g;
        logic [63:0] e;
        sel = 1; bc = 16'd2; g = got_q.size();
        fill_random(512);
        @(negedge clk); set_en(1'b1);
        drive_block(4, model_crcs(4), 4'hF, 40);
        @(negedge clk);
        checks++; if (mon_busy !== 1'b1) begin errors++; $display("FAIL ab_busy_pre: got %b expected 1", mon_busy); end
        set_en(1'b0);
        @(negedge clk);
        checks++; if (mon_busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b expected 0", mon_busy); end
        repeat (30) begin @(negedge clk); data_drv = 4'($urandom); end
        data_drv = 4'hF;
        checks++; if (got_q.size() - g !== 5) begin errors++; $display("FAIL ab_count: got %0d expected 5", got_q.size() - g); end
        for (int w = 0; w < 5 && g + w < got_q.size(); w++) begin
            e = {32'(4 * w), blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
            checks++; if (got_q[g + w] !== e) begin
                errors++; $display("FAIL ab_word%0d: got %h expected %h", w, got_q[g + w], e); end
        end
        checks++; if (mon_done !== 1'b0) begin errors++; $display("FAIL ab_done: got %b expected 0", mon_done); end
    endtask

    task automatic test_reset_mid();
        int g;
        sel = 1; bc = 16'd1; g = got_q.size();
        fill_random(512);
        @(negedge clk); set_en(1'b1);
        drive_block(4, model_crcs(4), 4'hF, 20);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if ({if4.Out_Data, if4.Out_Valid, if4.Out_Addr, if4.Block_Done, if4.Busy, if4.Rx_Done,
                       if4.Rx_Crc_Fail, if4.Rx_Timeout, if4.Fail_Block} !== 86'd0) begin
            errors++; $display("FAIL rm_outputs: not zero (data=%h addr=%h busy=%b)", if4.Out_Data, if4.Out_Addr, if4.Busy); end
        rst = 1'b0; set_en(1'b0); data_drv = 4'hF;
        repeat (20) @(negedge clk);
        checks++; if (got_q.size() - g !== 2) begin errors++; $display("FAIL rm_count: got %0d expected 2", got_q.size() - g); end
    endtask

    task automatic test_end_bit();
        int n;
        sel = 1; bc = 16'd1;
        fill_random(512);
        @(negedge clk); set_en(1'b1);
        drive_block(4, model_crcs(4), 4'b1110, -1);
        wait_done(100, n);
        checks++; if (mon_done !== 1'b1) begin errors++; $display("FAIL eb_done: got %b expected 1", mon_done); end
        checks++; if (mon_fail !== 1'b1) begin errors++; $display("FAIL eb_fail: got %b expected 1", mon_fail); end
        checks++; if (mon_fb !== 16'd0) begin errors++; $display("FAIL eb_failblk: got %0d expected 0", mon_fb); end
        @(negedge clk); set_en(1'b0);
        @(negedge clk);
        checks++; if ({mon_done, mon_fail, mon_to, mon_fb} !== 19'd0) begin
            errors++; $display("FAIL eb_clr: got done=%b fail=%b to=%b fb=%0d expected 0", mon_done, mon_fail, mon_to, mon_fb); end
    endtask

    initial begin
        test_reset();
        test_w1_ones();
        test_w4_ramp();
        test_multi_block();
        test_count_zero();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_end_bit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
